vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing_gen_axis.sv | 57 +++++
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, coordinate type and interval phase enum for the VGA timing generator.
package vga_pkg;

    localparam int H_DISP_DEF = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_PW_DEF   = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_DISP_DEF = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_PW_DEF   = 2;
    localparam int V_BP_DEF   = 33;
    localparam int CLK_DIV_DEF = 2;
    localparam int COORD_W    = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COORD_ZERO = 10'd0;
    localparam coord_t COORD_ONE  = 10'd1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        BACK  = 2'd1,
        DISP  = 2'd2,
        FRONT = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One timing axis: a wrapping counter over sync, back porch, display and front porch intervals.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC_LEN  = H_PW_DEF,
    parameter int BACK_LEN  = H_BP_DEF,
    parameter int DISP_LEN  = H_DISP_DEF,
    parameter int FRONT_LEN = H_FP_DEF
) (
    input  logic   CLOCK_50,
    input  logic   reset_n,
    input  logic   step,
    input  logic   clear,
    output coord_t count,
    output phase_t phase,
    output logic   wrap
);

    localparam int     TOTAL       = SYNC_LEN + BACK_LEN + DISP_LEN + FRONT_LEN;
    localparam coord_t LAST        = coord_t'(TOTAL - 1);
    localparam coord_t BACK_START  = coord_t'(SYNC_LEN);
    localparam coord_t DISP_START  = coord_t'(SYNC_LEN + BACK_LEN);
    localparam coord_t FRONT_START = coord_t'(SYNC_LEN + BACK_LEN + DISP_LEN);

    coord_t count_r;
    phase_t phase_s;

    // Position counter: advances on step, returns to zero after the last position
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= COORD_ZERO;
        end else if (clear) begin
            count_r <= COORD_ZERO;
        end else if (step) begin
            count_r <= (count_r == LAST) ? COORD_ZERO : count_r + COORD_ONE;
        end
    end

    // Interval decode from the current position
    always_comb begin
        phase_s = FRONT;
        if (count_r < BACK_START) begin
            phase_s = SYNC;
        end else if (count_r < DISP_START) begin
            phase_s = BACK;
        end else if (count_r < FRONT_START) begin
            phase_s = DISP;
        end else begin
            phase_s = FRONT;
        end
    end

    assign count = count_r;
    assign phase = phase_s;
    assign wrap  = step && !clear && (count_r == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/coordinate generator driven from CLOCK_50 through a pixel divider.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_DISP  = H_DISP_DEF,
    parameter int   H_FP    = H_FP_DEF,
    parameter int   H_PW    = H_PW_DEF,
    parameter int   H_BP    = H_BP_DEF,
    parameter int   V_DISP  = V_DISP_DEF,
    parameter int   V_FP    = V_FP_DEF,
    parameter int   V_PW    = V_PW_DEF,
    parameter int   V_BP    = V_BP_DEF,
    parameter int   CLK_DIV = CLK_DIV_DEF,
    parameter logic HS_POL  = 1'b0,
    parameter logic VS_POL  = 1'b0
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        en,
    output logic        HS,
    output logic        VS,
    output logic        blank,
    output logic        pix_en,
    output coord_t      row,
    output coord_t      col,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int     H_TOTAL     = H_PW + H_BP + H_DISP + H_FP;
    localparam int     V_TOTAL     = V_PW + V_BP + V_DISP + V_FP;
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam coord_t H_ACT_START = coord_t'(H_PW + H_BP);
    localparam coord_t V_ACT_START = coord_t'(V_PW + V_BP);

    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 1023");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be within 1..16");
    end

    logic [3:0] div_r;
    logic       pix_en_s;
    coord_t     h_count_s, v_count_s;
    phase_t     h_phase_s, v_phase_s;
    logic       h_wrap_s, v_wrap_s;
    coord_t     col_next_s, row_next_s;
    logic       hs_r, vs_r, blank_r, step_d_r, ls_r, fs_r;
    coord_t     row_r, col_r;
    logic       ls_next_s, fs_next_s;

    assign pix_en_s = reset_n && en && (div_r == DIV_LAST);

    // Pixel divider: free-runs while enabled, frozen otherwise
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_r <= 4'd0;
        end else if (en) begin
            div_r <= (div_r == DIV_LAST) ? 4'd0 : div_r + 4'd1;
        end
    end

    vga_axis_counter #(
        .SYNC_LEN (H_PW),
        .BACK_LEN (H_BP),
        .DISP_LEN (H_DISP),
        .FRONT_LEN(H_FP)
    ) u_h_axis (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .step    (pix_en_s),
        .clear   (1'b0),
        .count   (h_count_s),
        .phase   (h_phase_s),
        .wrap    (h_wrap_s)
    );

    vga_axis_counter #(
        .SYNC_LEN (V_PW),
        .BACK_LEN (V_BP),
        .DISP_LEN (V_DISP),
        .FRONT_LEN(V_FP)
    ) u_v_axis (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .step    (h_wrap_s),
        .clear   (1'b0),
        .count   (v_count_s),
        .phase   (v_phase_s),
        .wrap    (v_wrap_s)
    );

    // Coordinates relative to the active region, zero while blanked on that axis
    always_comb begin
        col_next_s = COORD_ZERO;
        row_next_s = COORD_ZERO;
        if (h_phase_s == DISP) begin
            col_next_s = h_count_s - H_ACT_START;
        end else begin
            col_next_s = COORD_ZERO;
        end
        if (v_phase_s == DISP) begin
            row_next_s = v_count_s - V_ACT_START;
        end else begin
            row_next_s = COORD_ZERO;
        end
    end

    // A start pulse needs the counter to have just moved onto zero, not merely sit there after reset
    assign ls_next_s = step_d_r && (h_count_s == COORD_ZERO);
    assign fs_next_s = ls_next_s && (v_count_s == COORD_ZERO);

    // Registered outputs trail the counters by one cycle and hold while disabled
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hs_r     <= HS_POL;
            vs_r     <= VS_POL;
            blank_r  <= 1'b1;
            row_r    <= COORD_ZERO;
            col_r    <= COORD_ZERO;
            step_d_r <= 1'b0;
            ls_r     <= 1'b0;
            fs_r     <= 1'b0;
        end else if (en) begin
            hs_r     <= (h_phase_s == SYNC) ? HS_POL : ~HS_POL;
            vs_r     <= (v_phase_s == SYNC) ? VS_POL : ~VS_POL;
            blank_r  <= !((h_phase_s == DISP) && (v_phase_s == DISP));
            row_r    <= row_next_s;
            col_r    <= col_next_s;
            step_d_r <= pix_en_s;
            ls_r     <= ls_next_s;
            fs_r     <= fs_next_s;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_r;

    // Frame counter steps together with the frame_start register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_r <= 16'd0;
        end else if (en && fs_next_s) begin
            frame_count_r <= frame_count_r + 16'd1;
        end
    end

    assign frame_count = frame_count_r;
`endif

    assign HS          = hs_r;
    assign VS          = vs_r;
    assign blank       = blank_r;
    assign row         = row_r;
    assign col         = col_r;
    assign pix_en      = pix_en_s;
    assign line_start  = ls_r && en;
    assign frame_start = fs_r && en;

endmodule
